// File: rtl/clk_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_step_ctrl_if
//
// Groups the stepping controller's board-side inputs and core-side outputs.
//
//   div_tick    divided square wave from the clock divider (asynchronous)
//   step_btn    raw, bouncy push-button, active-high (asynchronous)
//   mode_sw     slide switch, 0 = RUN, 1 = STEP (asynchronous)
//   halt        core halt request, level, synchronous to In_clk
//   cpu_en      one-cycle processor step enable
//   step_count  number of cpu_en pulses issued since reset (wraps)
//   state       0 = RUN, 1 = STEP, 2 = HALTED
//
// master: the board/core side that drives the inputs.
// slave : the controller itself.
// -----------------------------------------------------------------------------
interface clk_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             div_tick;
    logic             step_btn;
    logic             mode_sw;
    logic             halt;
    logic             cpu_en;
    logic [CNT_W-1:0] step_count;
    logic [1:0]       state;

    modport master (
        output div_tick, step_btn, mode_sw, halt,
        input  cpu_en, step_count, state
    );

    modport slave (
        input  div_tick, step_btn, mode_sw, halt,
        output cpu_en, step_count, state
    );
endinterface

// File: rtl/clk_step_ctrl.sv
// -----------------------------------------------------------------------------
// clk_step_ctrl
//
// Turns the clock divider's slow square wave into a one-cycle processor
// clock-enable in the fast In_clk domain. In RUN mode every rising edge of
// div_tick produces one step; in STEP mode every debounced button press
// produces one step. A halt request from the core freezes stepping until a
// button press wakes the controller up again. Issued steps are counted for
// the board display.
//
// Ports:
//   In_clk  board clock, all logic on its rising edge
//   reset   asynchronous, active-low reset
//   bus     clk_step_ctrl_if.slave
//             div_tick, step_btn, mode_sw : asynchronous, 2-flop synchronised
//             halt                        : synchronous level, used directly
//             cpu_en, step_count, state   : registered outputs
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable In_clk cycles needed before a new
//                    button level is accepted (1..65535)
//   CNT_W            width of step_count; must match the interface's CNT_W
// -----------------------------------------------------------------------------
module clk_step_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          CNT_W           = 16
) (
    input  logic           In_clk,
    input  logic           reset,
    clk_step_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Counter value at which the DEBOUNCE_CYCLES-th differing cycle is seen.
    localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

    // Synchronisers
    logic tick_s1, tick_s2, tick_d;
    logic btn_s1,  btn_s2;
    logic mode_s1, mode_s2;

    // Event detection
    logic        tick_rise;
    logic [15:0] db_cnt;
    logic        db_level;
    logic        press;

    // Control state and registered outputs
    state_e           st;
    logic             cpu_en_r;
    logic [CNT_W-1:0] step_cnt;
    logic             step_src;
    logic             fire;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers for the three asynchronous inputs. tick_d holds
    // the previous synchronised div_tick so a rising edge can be detected.
    // NOTE: every register here uses non-blocking assignment so that all flops
    // sample the values from before the clock edge; blocking assignment would
    // collapse the two synchroniser stages into one.
    // -------------------------------------------------------------------------
    always_ff @(posedge In_clk or negedge reset) begin
        if (!reset) begin
            tick_s1 <= 1'b0;
            tick_s2 <= 1'b0;
            tick_d  <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
        end else begin
            tick_s1 <= bus.div_tick;
            tick_s2 <= tick_s1;
            tick_d  <= tick_s2;
            btn_s1  <= bus.step_btn;
            btn_s2  <= btn_s1;
            mode_s1 <= bus.mode_sw;
            mode_s2 <= mode_s1;
        end
    end

    assign tick_rise = tick_s2 & ~tick_d;

    // -------------------------------------------------------------------------
    // Button debounce. The counter measures how long the synchronised button
    // has disagreed with the accepted level; any agreeing cycle (a glitch back
    // to the old level) restarts it. press is a one-cycle pulse on an accepted
    // 0->1 transition only; releases are silent.
    // -------------------------------------------------------------------------
    always_ff @(posedge In_clk or negedge reset) begin
        if (!reset) begin
            db_cnt   <= 16'd0;
            db_level <= 1'b0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s2 == db_level) begin
                db_cnt <= 16'd0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= btn_s2;
                db_cnt   <= 16'd0;
                press    <= btn_s2;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Step source selection. The source belongs to the state the controller is
    // in during this cycle, so on a mode switch the old mode's event is still
    // honoured exactly once and the new mode's source only applies from the
    // next cycle. HALTED has no source: its wake-up press is consumed.
    // halt suppresses the step unconditionally, even if an event coincides.
    // -------------------------------------------------------------------------
    always_comb begin
        step_src = 1'b0;
        unique case (st)
            ST_RUN:  step_src = tick_rise;
            ST_STEP: step_src = press;
            default: step_src = 1'b0;
        endcase
    end

    assign fire = step_src & ~bus.halt;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs. halt takes priority over a
    // simultaneous mode change. Reset clears cpu_en asynchronously, so a
    // pulse in flight is cut short immediately.
    // -------------------------------------------------------------------------
    always_ff @(posedge In_clk or negedge reset) begin
        if (!reset) begin
            st       <= ST_RUN;
            cpu_en_r <= 1'b0;
            step_cnt <= '0;
        end else begin
            cpu_en_r <= fire;
            if (fire) begin
                step_cnt <= step_cnt + CNT_W'(1);   // wraps silently
            end

            unique case (st)
                ST_RUN: begin
                    if (bus.halt) begin
                        st <= ST_HALTED;
                    end else if (mode_s2) begin
                        st <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (bus.halt) begin
                        st <= ST_HALTED;
                    end else if (!mode_s2) begin
                        st <= ST_RUN;
                    end
                end
                ST_HALTED: begin
                    if (!bus.halt && press) begin
                        st <= mode_s2 ? ST_STEP : ST_RUN;
                    end
                end
                default: st <= ST_RUN;   // unused encoding recovers to RUN
            endcase
        end
    end

    assign bus.cpu_en     = cpu_en_r;
    assign bus.step_count = step_cnt;
    assign bus.state      = st;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_step_ctrl
//
// Bench for clk_step_ctrl with DEBOUNCE_CYCLES = 4. A reference model runs on
// every rising clock edge from the input levels the DUT samples at that edge
// and pushes each expected cpu_en pulse (edge number and step_count) into a
// scoreboard queue. A monitor on the falling edge pops and compares whenever
// cpu_en is high, and also tracks state and step_count every cycle.
// -----------------------------------------------------------------------------
module tb_clk_step_ctrl;

    localparam int D  = 4;
    localparam int CW = 16;

    logic In_clk = 1'b0;
    logic reset  = 1'b1;

    clk_step_ctrl_if #(.CNT_W(CW)) bus ();

    clk_step_ctrl #(
        .DEBOUNCE_CYCLES (16'(D)),
        .CNT_W           (CW)
    ) dut (
        .In_clk (In_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 In_clk = ~In_clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int edge_n = 0;
    int tc     = 0;

    typedef struct {
        int            edge_no;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state, in the output's own terms: 0 RUN, 1 STEP, 2 HALTED
    int            m_state;
    logic [CW-1:0] m_count;
    bit            m_lvl;
    bit            m_press;
    int            m_run;
    // Input samples taken at previous edges; index 0 is the most recent one
    bit            tk_h[3];
    bit            md_h[2];
    bit            bt_h[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_state = 0;
        m_count = '0;
        m_lvl   = 1'b0;
        m_press = 1'b0;
        m_run   = 0;
        tk_h    = '{1'b0, 1'b0, 1'b0};
        md_h    = '{1'b0, 1'b0};
        bt_h    = '{1'b0, 1'b0};
        sb_q.delete();
    endfunction

    // Free-running divider output: toggles every 4 cycles
    function automatic bit ft();
        bit v;
        v  = ((tc / 4) % 2) == 1;
        tc = tc + 1;
        return v;
    endfunction

    // Drive div_tick (other inputs are set directly) and advance one cycle;
    // returns 1 time unit after the next rising edge.
    task automatic stp(input bit t);
        bus.div_tick = t;
        @(posedge In_clk);
        #1;
    endtask

    // n full divider periods: 4 cycles high, 4 cycles low
    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (4) stp(1'b1);
            repeat (4) stp(1'b0);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model. A level sampled at edge k is visible to the controller
    // after two synchroniser stages, i.e. when deciding at edge k+2; a div_tick
    // rise is a sampled 0 followed by a sampled 1. halt acts at the edge where
    // it is sampled. The button is accepted after D consecutive visible cycles
    // that differ from the accepted level.
    // -------------------------------------------------------------------------
    always @(posedge In_clk) begin : model
        bit   rise, mode_v, btn_v, pr, fire;
        exp_t e;
        edge_n++;
        if (!reset) begin
            model_clear();
        end else begin
            rise   = tk_h[1] && !tk_h[2];
            mode_v = md_h[1];
            btn_v  = bt_h[1];
            pr     = m_press;
            fire   = 1'b0;

            if (bus.halt) begin
                m_state = 2;
            end else begin
                case (m_state)
                    0: begin
                        fire = rise;
                        if (mode_v) m_state = 1;
                    end
                    1: begin
                        fire = pr;
                        if (!mode_v) m_state = 0;
                    end
                    default: begin
                        if (pr) m_state = mode_v ? 1 : 0;
                    end
                endcase
            end

            if (fire) begin
                m_count   = m_count + 1'b1;
                e.edge_no = edge_n;
                e.cnt     = m_count;
                sb_q.push_back(e);
            end

            m_press = 1'b0;
            if (btn_v == m_lvl) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == D) begin
                    m_lvl   = btn_v;
                    m_run   = 0;
                    m_press = btn_v;
                end
            end

            tk_h[2] = tk_h[1];
            tk_h[1] = tk_h[0];
            tk_h[0] = bus.div_tick;
            md_h[1] = md_h[0];
            md_h[0] = bus.mode_sw;
            bt_h[1] = bt_h[0];
            bt_h[0] = bus.step_btn;
        end
    end

    // -------------------------------------------------------------------------
    // Monitor: compares on the falling edge, away from the active edge.
    // -------------------------------------------------------------------------
    always @(negedge In_clk) begin : monitor
        bit   exp_en;
        exp_t e;
        exp_en = (sb_q.size() > 0) && (sb_q[0].edge_no == edge_n);
        check("cpu_en", 32'(bus.cpu_en), 32'(exp_en));
        if (bus.cpu_en === 1'b1) pulses++;
        if (exp_en) begin
            e = sb_q.pop_front();
            check("pulse step_count", 32'(bus.step_count), 32'(e.cnt));
        end
        check("state", 32'(bus.state), 32'(m_state));
        check("step_count", 32'(bus.step_count), 32'(m_count));
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : stim
        int p0;
        int th, bh, hh;
        bit rt;

        bus.div_tick = 1'b0;
        bus.step_btn = 1'b0;
        bus.mode_sw  = 1'b0;
        bus.halt     = 1'b0;
        reset        = 1'b0;
        model_clear();
        repeat (3) stp(1'b0);
        check("reset cpu_en", 32'(bus.cpu_en), 0);
        check("reset step_count", 32'(bus.step_count), 0);
        check("reset state", 32'(bus.state), 0);
        reset = 1'b1;

        // Free-run: 10 divider periods give 10 steps
        p0 = pulses;
        repeat (4) stp(1'b0);
        pulse_ticks(10);
        check("run pulses", pulses - p0, 10);
        check("run count", 32'(bus.step_count), 10);

        // STEP mode: ticks ignored, one bouncy press gives exactly one step
        bus.mode_sw = 1'b1;
        p0 = pulses;
        repeat (24) stp(ft());
        check("step ignores ticks", pulses - p0, 0);
        check("step state", 32'(bus.state), 1);
        for (int g = 0; g < 3; g++) begin
            bus.step_btn = 1'b1;
            repeat ($urandom_range(1, 2)) stp(ft());
            bus.step_btn = 1'b0;
            repeat ($urandom_range(1, 2)) stp(ft());
        end
        bus.step_btn = 1'b1;
        repeat (10) stp(ft());
        for (int g = 0; g < 2; g++) begin
            bus.step_btn = 1'b0;
            repeat ($urandom_range(1, 2)) stp(ft());
            bus.step_btn = 1'b1;
            stp(ft());
        end
        bus.step_btn = 1'b0;
        repeat (12) stp(ft());
        check("press pulses", pulses - p0, 1);
        check("press count", 32'(bus.step_count), 11);

        // Halt coinciding with a tick rise, then wake-up press, then a tick
        bus.mode_sw = 1'b0;
        repeat (8) stp(1'b0);
        p0 = pulses;
        stp(1'b1);
        stp(1'b1);
        bus.halt = 1'b1;
        stp(1'b1);
        repeat (40) stp(ft());
        check("halt pulses", pulses - p0, 0);
        check("halt state", 32'(bus.state), 2);
        bus.halt     = 1'b0;
        bus.step_btn = 1'b1;
        repeat (8) stp(1'b0);
        bus.step_btn = 1'b0;
        repeat (8) stp(1'b0);
        check("wake state", 32'(bus.state), 0);
        check("wake no pulse", pulses - p0, 0);
        pulse_ticks(1);
        check("after wake pulses", pulses - p0, 1);
        check("after wake count", 32'(bus.step_count), 12);

        // Counter wrap
        force dut.step_cnt = 16'hFFFE;
        m_count = 16'hFFFE;
        #1;
        release dut.step_cnt;
        p0 = pulses;
        pulse_ticks(2);
        check("wrap pulses", pulses - p0, 2);
        check("wrap count", 32'(bus.step_count), 0);

        // Reset during a cpu_en pulse with the debounce counter at 2
        repeat (4) stp(1'b0);
        bus.step_btn = 1'b1;
        stp(1'b0);
        stp(1'b1);
        stp(1'b1);
        stp(1'b1);
        check("cpu_en before reset", 32'(bus.cpu_en), 1);
        reset = 1'b0;
        model_clear();
        bus.mode_sw = 1'b1;
        #1;
        check("reset kills cpu_en", 32'(bus.cpu_en), 0);
        check("reset clears count", 32'(bus.step_count), 0);
        check("reset state RUN", 32'(bus.state), 0);
        repeat (3) stp(1'b0);
        reset = 1'b1;
        p0 = pulses;
        repeat (6) stp(1'b0);
        check("fresh debounce early", pulses - p0, 0);
        repeat (3) stp(1'b0);
        check("fresh debounce pulse", pulses - p0, 1);
        check("fresh debounce count", 32'(bus.step_count), 1);

        // Mode switch to STEP in the same cycle as a tick rise
        bus.step_btn = 1'b0;
        bus.mode_sw  = 1'b0;
        repeat (10) stp(1'b0);
        check("back to RUN", 32'(bus.state), 0);
        p0 = pulses;
        bus.mode_sw = 1'b1;
        repeat (4) stp(1'b1);
        repeat (32) stp(ft());
        check("switch pulses", pulses - p0, 1);
        check("switch state", 32'(bus.state), 1);

        // Randomised traffic against the model
        th = 0;
        bh = 0;
        hh = 0;
        rt = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (th == 0) begin
                rt = !rt;
                th = $urandom_range(2, 6);
            end
            th--;
            if (bh == 0) begin
                bus.step_btn = !bus.step_btn;
                bh = $urandom_range(1, 10);
            end
            bh--;
            if ($urandom_range(0, 59) == 0) bus.mode_sw = !bus.mode_sw;
            if (hh == 0) begin
                bus.halt = ($urandom_range(0, 5) == 0);
                hh = $urandom_range(1, 12);
            end
            hh--;
            stp(rt);
        end

        bus.halt = 1'b0;
        repeat (10) stp(1'b0);
        check("scoreboard drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
